// File: rtl/mux_rr_nxw.sv
// mux_rr_nxw: N-channel by WIDTH-bit valid/ready multiplexer with a one-entry
// registered output stage.
//
// Channel selection:
//   mode = 0 : explicit, the channel named by sel is granted (none if sel >= N)
//   mode = 1 : round-robin, first valid channel scanning from ptr upward
//
// Build option:
//   MUX_RR_NXW_RR_EN  defined   -> round-robin mode and the rotation pointer exist
//                     undefined -> mode is ignored, explicit select only
//
// At most one in_ready bit is high per cycle, and only when the output register
// can take a word, i.e. when it is empty or being drained on the same edge.
// A drain and a load on the same edge keep out_valid high with the new word, so
// a continuously ready consumer sees one word per cycle.
module mux_rr_nxw #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0][WIDTH-1:0]   in_data,
   input  logic [N-1:0]              in_valid,
   output logic [N-1:0]              in_ready,
   input  logic [SELW-1:0]           sel,
   input  logic                      mode,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SELW-1:0]  grant;
   logic             grant_ok;
   logic             can_load;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;

   logic [31:0]      sel_ext;
   logic             sel_ok;

   // Explicit select is only a grant when sel names an existing channel; this
   // matters when N is not a power of two.
   assign sel_ext = 32'(sel);
   assign sel_ok  = (sel_ext < 32'(N));

`ifdef MUX_RR_NXW_RR_EN

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_next;
   logic [SELW-1:0] rr_idx;
   logic            rr_ok;

   // Round-robin scan: first valid channel at or after ptr, modulo N.
   // Walking the offsets from high to low leaves the smallest offset as winner.
   always_comb begin
      int j;
      j      = 0;
      rr_idx = '0;
      rr_ok  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (in_valid[j]) begin
            rr_idx = SELW'(j);
            rr_ok  = 1'b1;
         end
      end
   end

   // Choose the grant source from the current mode; out-of-range selects
   // collapse to index 0 so the data mux never sees an unused index.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (mode) begin
         grant    = rr_idx;
         grant_ok = rr_ok;
      end else if (sel_ok) begin
         grant    = sel;
         grant_ok = 1'b1;
      end
   end

   // Pointer moves past the channel that was just served, wrapping at N-1.
   always_comb begin
      ptr_next = grant + SELW'(1);
      if (32'(grant) == 32'(N - 1)) begin
         ptr_next = '0;
      end
   end

   // Rotation pointer advances only on a round-robin transfer; it survives
   // mode changes so switching back resumes the rotation where it stopped.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (xfer && mode) begin
         ptr <= ptr_next;
      end
   end

`else

   // mode has no effect in the explicit-only build.
   logic unused_mode;
   assign unused_mode = mode;

   // Explicit-only grant; out-of-range selects grant nothing.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (sel_ok) begin
         grant    = sel;
         grant_ok = 1'b1;
      end
   end

`endif

   assign can_load = !out_valid || out_ready;

   // One-hot accept towards the granted channel, suppressed during reset so a
   // producer never believes a word was taken while the register is clearing.
   always_comb begin
      in_ready = '0;
      if (grant_ok && can_load && !reset) begin
         in_ready[grant] = 1'b1;
      end
   end

   assign xfer       = |(in_ready & in_valid);
   assign grant_data = in_data[grant];

   // Output register: reset wins, then load (also covers drain-and-load),
   // then a plain drain; otherwise the held word stays put.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_chan  <= grant;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_rr_nxw.sv
// Bench for mux_rr_nxw (WIDTH=32, N=4): directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the selection rules and the one-entry output register.
// Adapts to the MUX_RR_NXW_RR_EN build option.
module tb_mux_rr_nxw;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N-1:0][WIDTH-1:0] in_data;
   logic [N-1:0]            in_valid;
   logic [N-1:0]            in_ready;
   logic [SELW-1:0]         sel;
   logic                    mode;
   logic [WIDTH-1:0]        out_data;
   logic [SELW-1:0]         out_chan;
   logic                    out_valid;
   logic                    out_ready;

   int errors = 0;
   int checks = 0;

   // model state
   bit               m_valid = 1'b0;
   logic [WIDTH-1:0] m_data  = '0;
   int               m_chan  = 0;
   int               m_ptr   = 0;
   int               ncyc    = 0;

   mux_rr_nxw #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Granted channel under the current inputs and model pointer, -1 for none.
   function automatic int exp_grant();
`ifdef MUX_RR_NXW_RR_EN
      if (mode) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (in_valid[k]) return k;
         end
         return -1;
      end
`endif
      if (int'(sel) < N) return int'(sel);
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g;
      g = exp_grant();
      if (reset || g < 0 || !(!m_valid || out_ready)) return '0;
      return N'(1) << g;
   endfunction

   // Model update at each rising edge, from the pre-edge inputs and state.
   always @(posedge clk) begin : model
      int g;
      bit xfer;
      g = exp_grant();
      ncyc++;
      if (reset) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_chan  = 0;
         m_ptr   = 0;
      end else begin
         xfer = (g >= 0) && (!m_valid || out_ready) && in_valid[g];
         if (xfer) begin
            m_data  = in_data[g];
            m_chan  = g;
            m_valid = 1'b1;
`ifdef MUX_RR_NXW_RR_EN
            if (mode) m_ptr = (g + 1) % N;
`endif
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (ncyc > 0) begin
         chk("in_ready",  64'(in_ready),  64'(exp_ready()));
         chk("out_valid", 64'(out_valid), 64'(m_valid));
         chk("out_data",  64'(out_data),  64'(m_data));
         chk("out_chan",  64'(out_chan),  64'(m_chan));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
   logic [WIDTH-1:0] d3;

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = '0;
      sel       = '0;
      mode      = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_chan",  64'(out_chan),  64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      reset = 1'b0;

      // explicit select of channel 2
      mode        = 1'b0;
      sel         = 2'd2;
      in_data[2]  = 32'hDEADBEEF;
      in_valid    = 4'b0100;
      out_ready   = 1'b1;
      #1;
      chk("sel2_in_ready", 64'(in_ready), 64'h4);
      tick();
      chk("sel2_out_data",  64'(out_data),  64'hDEADBEEF);
      chk("sel2_out_chan",  64'(out_chan),  64'd2);
      chk("sel2_out_valid", 64'(out_valid), 64'd1);
      in_valid = '0;
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // backpressure on channel 1, then drain-and-load with no bubble
      sel        = 2'd1;
      in_valid   = 4'b0010;
      in_data[1] = 32'hA1A1A1A1;
      out_ready  = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_data[1] = $urandom;
         #1;
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("stall_out_data",  64'(out_data),  64'hA1A1A1A1);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready  = 1'b1;
      in_data[1] = 32'hB2B2B2B2;
      #1;
      chk("resume_in_ready", 64'(in_ready), 64'h2);
      tick();
      chk("resume_out_data",  64'(out_data),  64'hB2B2B2B2);
      chk("resume_out_valid", 64'(out_valid), 64'd1);
      chk("resume_out_chan",  64'(out_chan),  64'd1);
      in_valid = '0;
      tick();

`ifdef MUX_RR_NXW_RR_EN
      // round-robin over four always-valid channels
      mode     = 1'b1;
      in_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rr_seq_chan", 64'(out_chan), 64'(rr_exp[i]));
      end
      tick();
      chk("rr_seq_chan7", 64'(out_chan), 64'd2);
      // pointer now 3; only channel 1 valid -> wrap-around grant
      in_valid = 4'b0010;
      #1;
      chk("rr_wrap_in_ready", 64'(in_ready), 64'h2);
      tick();
      chk("rr_wrap_chan", 64'(out_chan), 64'd1);
      in_valid = 4'b1111;
      #1;
      chk("rr_ptr2_in_ready", 64'(in_ready), 64'h4);
`endif

      // channel 3 via sel; in the explicit-only build mode=1 must be ignored
`ifdef MUX_RR_NXW_RR_EN
      mode = 1'b0;
`else
      mode = 1'b1;
`endif
      sel       = 2'd3;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d3 = $urandom;
         in_data[3] = d3;
         #1;
         chk("sel3_in_ready", 64'(in_ready), 64'h8);
         tick();
         chk("sel3_out_chan", 64'(out_chan), 64'd3);
         chk("sel3_out_data", 64'(out_data), 64'(d3));
      end

      // reset while holding a word with all channels valid
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      reset     = 1'b1;
      #1;
      chk("in_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_data",  64'(out_data),  64'd0);
      chk("post_rst_chan",  64'(out_chan),  64'd0);
      reset     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("first_grant_ready", 64'(in_ready), 64'h1);
      tick();
      chk("first_grant_chan", 64'(out_chan), 64'd0);

      // randomized traffic, checked each cycle by the compare process
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 63) == 0);
         mode      = 1'($urandom);
         sel       = SELW'($urandom);
         in_valid  = N'($urandom);
         for (int k = 0; k < N; k++) in_data[k] = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
